// File: rtl/seg_pkg.sv
// Shared constants and types for the two-digit seven-segment scan multiplexer.
package seg_pkg;

  localparam logic [13:0] ER_CODE    = 14'b0000110_0101111;
  localparam logic [13:0] BLANK_CODE = 14'h3FFF;
  localparam logic [6:0]  BLANK_SEG  = 7'h7F;
  localparam logic [3:0]  BLANK_AN   = 4'hF;

  typedef enum logic {
    FLT_STABLE  = 1'b0,
    FLT_PENDING = 1'b1
  } filt_state_t;

  typedef logic [1:0] digit_ptr_t;

endpackage

// File: rtl/seg_stab_filter.sv
// Brings the switch-decoder code into the clk domain and commits a new code only
// after it has held steady for STABLE_TICKS refresh ticks.
module seg_stab_filter
  import seg_pkg::*;
#(
  parameter int STABLE_TICKS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] seg_in,
  input  logic        tick,
  output logic [13:0] committed
);

  localparam int CW = $clog2(STABLE_TICKS) + 1;

  logic [13:0] sync1_reg;
  logic [13:0] sync2_reg;
  filt_state_t state_reg, state_next;
  logic [13:0] cand_reg, cand_next;
  logic [CW-1:0] count_reg, count_next;
  logic [13:0] committed_reg, committed_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg     <= BLANK_CODE;
      sync2_reg     <= BLANK_CODE;
      state_reg     <= FLT_STABLE;
      cand_reg      <= BLANK_CODE;
      count_reg     <= '0;
      committed_reg <= BLANK_CODE;
    end else begin
      sync1_reg     <= seg_in;
      sync2_reg     <= sync1_reg;
      state_reg     <= state_next;
      cand_reg      <= cand_next;
      count_reg     <= count_next;
      committed_reg <= committed_next;
    end
  end

  // An input change always restarts the count, even when it lands on a tick.
  always_comb begin
    state_next     = state_reg;
    cand_next      = cand_reg;
    count_next     = count_reg;
    committed_next = committed_reg;
    case (state_reg)
      FLT_STABLE: begin
        if (sync2_reg != committed_reg) begin
          state_next = FLT_PENDING;
          cand_next  = sync2_reg;
          count_next = '0;
        end
      end
      FLT_PENDING: begin
        if (sync2_reg == committed_reg) begin
          state_next = FLT_STABLE;
        end else if (sync2_reg != cand_reg) begin
          cand_next  = sync2_reg;
          count_next = '0;
        end else if (tick) begin
          if (count_reg == CW'(STABLE_TICKS - 1)) begin
            committed_next = cand_reg;
            state_next     = FLT_STABLE;
          end else begin
            count_next = count_reg + CW'(1);
          end
        end
      end
      default: state_next = FLT_STABLE;
    endcase
  end

  assign committed = committed_reg;

endmodule

// File: rtl/seg_scan_mux.sv
// Two-digit multiplexed seven-segment driver with input debounce and guard blanking.
// Define SEG_BLINK_EN to blink the display while the "Er" code is committed.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD        = 500,
  parameter int STABLE_TICKS = 8,
  parameter int BLINK_TICKS  = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] seg_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [PW-1:0] presc_reg;
  digit_ptr_t    ptr_reg;
  logic          tick;
  logic          in_guard;
  logic [13:0]   committed;
  logic [3:0]    an_next;
  logic [6:0]    digit_seg;
  logic          blank_digits;
  logic [6:0]    seg_reg;
  logic [3:0]    an_reg;
  logic          frame_tick_reg;

  assign tick     = (presc_reg == PW'(REFRESH_DIV - 1));
  assign in_guard = (presc_reg < PW'(GUARD));

  seg_stab_filter #(
    .STABLE_TICKS(STABLE_TICKS)
  ) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .seg_in   (seg_in),
    .tick     (tick),
    .committed(committed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
      ptr_reg   <= '0;
    end else if (tick) begin
      presc_reg <= '0;
      ptr_reg   <= ptr_reg + 2'd1;
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  // Only the two real digits (positions 0 and 1) ever get a live anode.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_an
      if (gi < 2) begin : g_live
        assign an_next[gi] = in_guard || (ptr_reg != digit_ptr_t'(gi));
      end else begin : g_dead
        assign an_next[gi] = 1'b1;
      end
    end
  endgenerate

  always_comb begin
    digit_seg = BLANK_SEG;
    case (ptr_reg)
      2'd0:    digit_seg = committed[6:0];
      2'd1:    digit_seg = committed[13:7];
      default: ;
    endcase
  end

`ifdef SEG_BLINK_EN
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [BW-1:0] blink_cnt_reg;
  logic          blink_on_reg;
  logic [13:0]   committed_prev_reg;
  logic          committed_changed;

  assign committed_changed = (committed != committed_prev_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_reg      <= '0;
      blink_on_reg       <= 1'b1;
      committed_prev_reg <= BLANK_CODE;
    end else begin
      committed_prev_reg <= committed;
      if (committed_changed) begin
        blink_cnt_reg <= '0;
        blink_on_reg  <= 1'b1;
      end else if (tick) begin
        if (blink_cnt_reg == BW'(BLINK_TICKS - 1)) begin
          blink_cnt_reg <= '0;
          blink_on_reg  <= ~blink_on_reg;
        end else begin
          blink_cnt_reg <= blink_cnt_reg + BW'(1);
        end
      end
    end
  end

  // The phase restart lands one cycle after a commit, so a fresh code is never blanked early.
  assign blank_digits = (committed == ER_CODE) && !blink_on_reg && !committed_changed;
`else
  assign blank_digits = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_reg        <= BLANK_SEG;
      an_reg         <= BLANK_AN;
      frame_tick_reg <= 1'b0;
    end else begin
      seg_reg        <= blank_digits ? BLANK_SEG : digit_seg;
      an_reg         <= an_next;
      frame_tick_reg <= tick && (ptr_reg == 2'd3);
    end
  end

  assign seg        = seg_reg;
  assign an         = an_reg;
  assign frame_tick = frame_tick_reg;
  assign dp         = 1'b1;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: constant vector table, corner sequences and
// randomized input against a cycle-count based reference model.
module tb_seg_scan_mux;
  import seg_pkg::*;

  localparam int RD = 4;
  localparam int GD = 1;
  localparam int ST = 3;
  localparam int BT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [13:0] seg_in = 14'h3FFF;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg_scan_mux #(
    .REFRESH_DIV (RD),
    .GUARD       (GD),
    .STABLE_TICKS(ST),
    .BLINK_TICKS (BT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_tick(frame_tick)
  );

  // Reference model: time is a plain edge count since reset release.
  int          m_cyc;
  logic [13:0] m_s1, m_s2, m_prev_synced, m_committed;
  int          m_run_ticks, m_blink_ticks;
  logic [6:0]  m_seg;
  logic [3:0]  m_an;
  logic        m_ft;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0;
    m_s1 = 14'h3FFF; m_s2 = 14'h3FFF; m_prev_synced = 14'h3FFF; m_committed = 14'h3FFF;
    m_run_ticks = 0; m_blink_ticks = 0;
    m_seg = 7'h7F; m_an = 4'hF; m_ft = 1'b0;
  endtask

  task automatic model_edge();
    int presc, ptr;
    logic tick, phase_on, changed;
    logic [13:0] synced;
    logic [6:0] disp;
    presc    = m_cyc % RD;
    ptr      = (m_cyc / RD) % 4;
    tick     = (presc == RD - 1);
    phase_on = ((m_blink_ticks / BT) % 2) == 0;
    if (presc < GD || ptr > 1) m_an = 4'hF;
    else m_an = (ptr == 0) ? 4'hE : 4'hD;
    if (ptr == 0) disp = m_committed[6:0];
    else if (ptr == 1) disp = m_committed[13:7];
    else disp = 7'h7F;
`ifdef SEG_BLINK_EN
    if (m_committed == ER_CODE && !phase_on) disp = 7'h7F;
`else
    if (phase_on) disp = disp;
`endif
    m_seg = disp;
    m_ft  = tick && (ptr == 3);
    synced  = m_s2;
    changed = 1'b0;
    if (synced != m_prev_synced) m_run_ticks = 0;
    else if (tick && synced != m_committed) begin
      m_run_ticks++;
      if (m_run_ticks == ST) begin
        m_committed = synced;
        changed = 1'b1;
      end
    end
    if (changed) m_blink_ticks = 0;
    else if (tick) m_blink_ticks++;
    m_prev_synced = synced;
    m_s2 = m_s1;
    m_s1 = seg_in;
    m_cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("seg", {25'd0, seg}, {25'd0, m_seg});
    check("an", {28'd0, an}, {28'd0, m_an});
    check("dp", {31'd0, dp}, 32'd1);
    check("frame_tick", {31'd0, frame_tick}, {31'd0, m_ft});
  endtask

  task automatic check_blank(input string name);
    check({name, "_seg"}, {25'd0, seg}, 32'h7F);
    check({name, "_an"}, {28'd0, an}, 32'hF);
    check({name, "_ft"}, {31'd0, frame_tick}, 32'd0);
    check({name, "_dp"}, {31'd0, dp}, 32'd1);
  endtask

  typedef struct {
    logic [13:0] code;
    int          hold;
    logic [13:0] exp_committed;
    logic        exp_pending;
  } vec_t;

  localparam logic [6:0] D1 = 7'h79, D2 = 7'h24, D3 = 7'h30, D4 = 7'h19;
  localparam logic [6:0] D5 = 7'h12, D6 = 7'h02, D7 = 7'h78, D8 = 7'h00;

  vec_t        vecs [9];
  logic [3:0]  exp_an [16];
  logic [13:0] pool [6];
  logic [13:0] c12, c81, c34, c56, c78, c45;
  int          ft_cnt, blank_cnt, vis_cnt;
  logic [31:0] rnd;

  initial begin
    c12 = {D1, D2}; c81 = {D8, D1}; c34 = {D3, D4};
    c56 = {D5, D6}; c78 = {D7, D8}; c45 = {D4, D5};
    vecs[0] = '{c12,   20, c12,   1'b0};
    vecs[1] = '{c81,    8, c12,   1'b1};
    vecs[2] = '{c12,   20, c12,   1'b0};
    vecs[3] = '{c34,    8, c12,   1'b1};
    vecs[4] = '{c56,    8, c12,   1'b1};
    vecs[5] = '{c78,    8, c12,   1'b1};
    vecs[6] = '{c78,   20, c78,   1'b0};
    vecs[7] = '{14'h3FFF, 20, 14'h3FFF, 1'b0};
    vecs[8] = '{c81,   20, c81,   1'b0};
    exp_an = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
               4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    pool = '{c12, c81, ER_CODE, 14'h3FFF, c45, c78};

    // Power-up reset
    #2 rst_n = 1'b0;
    #1 check_blank("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;

    // Scan pattern and frame period with a blank input
    ft_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (i < 16) check("scan_an", {28'd0, an}, {28'd0, exp_an[i]});
      if (frame_tick) ft_cnt++;
    end
    check("frame_count", ft_cnt, 4);
    $display("[TB] scan frame: %0d frame ticks in 64 clks", ft_cnt);

    // Vector table
    for (int v = 0; v < 9; v++) begin
      seg_in = vecs[v].code;
      repeat (vecs[v].hold) step();
      check("vec_committed", {18'd0, dut.u_filter.committed_reg}, {18'd0, vecs[v].exp_committed});
      check("vec_pending", {31'd0, dut.u_filter.state_reg == FLT_PENDING}, {31'd0, vecs[v].exp_pending});
      $display("[TB] vec %0d code=%h hold=%0d committed=%h", v, vecs[v].code, vecs[v].hold,
               dut.u_filter.committed_reg);
    end

    // Reset in the middle of a pending candidate
    seg_in = c45;
    repeat (10) step();
    check("pre_rst_pending", {31'd0, dut.u_filter.state_reg == FLT_PENDING}, 32'd1);
    rst_n = 1'b0;
    #1 check_blank("mid_reset");
    check("mid_reset_committed", {18'd0, dut.u_filter.committed_reg}, 32'h3FFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 11) check("recommit_early", {18'd0, dut.u_filter.committed_reg}, 32'h3FFF);
      if (k == 12) check("recommit_done", {18'd0, dut.u_filter.committed_reg}, {18'd0, c45});
    end
    $display("[TB] reset mid-pending: committed=%h after 12 clks", dut.u_filter.committed_reg);

    // "Er" code: blinks only with SEG_BLINK_EN
    seg_in = ER_CODE;
    repeat (20) step();
    blank_cnt = 0;
    vis_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (an == 4'hE && seg == 7'h7F) blank_cnt++;
      if (an == 4'hE && seg == ER_CODE[6:0]) vis_cnt++;
    end
    check("er_visible", {31'd0, vis_cnt > 0}, 32'd1);
`ifdef SEG_BLINK_EN
    check("er_blank", {31'd0, blank_cnt > 0}, 32'd1);
`else
    check("er_blank", blank_cnt, 0);
`endif
    $display("[TB] er code: visible=%0d blank=%0d", vis_cnt, blank_cnt);

    // Randomized input segments
    for (int t = 0; t < 300; t++) begin
      int r, hold;
      r = $urandom_range(0, 6);
      hold = $urandom_range(1, 24);
      if (r < 6) seg_in = pool[r];
      for (int h = 0; h < hold; h++) begin
        if (r == 6) begin
          rnd = $urandom();
          seg_in = rnd[13:0];
        end
        step();
      end
      check("rand_committed", {18'd0, dut.u_filter.committed_reg}, {18'd0, m_committed});
      $display("[TB] rand %0d kind=%0d hold=%0d committed=%h", t, r, hold, m_committed);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
